// File: rtl/layer_stream_sequencer_if.sv
// layer_stream_sequencer_if: vector capture and element stream handshake bundle
interface layer_stream_sequencer_if #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16
);
  localparam int IDX_W = NUM_INPUT > 1 ? $clog2(NUM_INPUT) : 1;
  logic [NUM_INPUT*INPUT_WIDTH-1:0] vec_data;
  logic                             vec_valid;
  logic                             vec_ready;
  logic [INPUT_WIDTH-1:0]           elem_data;
  logic                             elem_valid;
  logic                             elem_ready;
  logic                             last;
  logic [IDX_W-1:0]                 index;
  logic                             busy;
  logic                             overrun;
  logic                             clear_overrun;
  modport master (
    input  vec_data, vec_valid, elem_ready, clear_overrun,
    output vec_ready, elem_data, elem_valid, last, index, busy, overrun
  );
  modport slave (
    output vec_data, vec_valid, elem_ready, clear_overrun,
    input  vec_ready, elem_data, elem_valid, last, index, busy, overrun
  );
endinterface

// File: rtl/layer_stream_sequencer.sv
// layer_stream_sequencer: serialises a captured packed vector into an indexed element stream
module layer_stream_sequencer #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  layer_stream_sequencer_if.master    bus
);
  localparam int IDX_W = NUM_INPUT > 1 ? $clog2(NUM_INPUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUT - 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  logic [0:0]                       state;
  logic [NUM_INPUT*INPUT_WIDTH-1:0] buf_q;
  assign bus.vec_ready = state == IDLE;
  // buf_q holds the not-yet-emitted elements, shifted down so the next one sits in the low lane
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      buf_q          <= '0;
      bus.elem_data  <= '0;
      bus.elem_valid <= 1'b0;
      bus.last       <= 1'b0;
      bus.index      <= '0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.overrun <= (bus.vec_valid && state == STREAM) || (bus.overrun && !bus.clear_overrun);
      if (state == IDLE) begin
        if (bus.vec_valid) begin
          state          <= STREAM;
          bus.elem_data  <= bus.vec_data[INPUT_WIDTH-1:0];
          buf_q          <= bus.vec_data >> INPUT_WIDTH;
          bus.index      <= '0;
          bus.last       <= NUM_INPUT == 1;
          bus.elem_valid <= 1'b1;
          bus.busy       <= 1'b1;
        end
      end else if (bus.elem_ready) begin
        if (bus.last) begin
          state          <= IDLE;
          bus.elem_valid <= 1'b0;
          bus.busy       <= 1'b0;
          bus.last       <= 1'b0;
          bus.index      <= '0;
        end else begin
          bus.elem_data <= buf_q[INPUT_WIDTH-1:0];
          buf_q         <= buf_q >> INPUT_WIDTH;
          bus.index     <= bus.index + 1'b1;
          bus.last      <= bus.index == LAST_IDX - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_layer_stream_sequencer.sv
// tb_layer_stream_sequencer: directed checks of streaming, backpressure, overrun and reset
module tb_layer_stream_sequencer;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [N*W-1:0] V1   = 64'h0004_0003_0002_0001;
  localparam logic [N*W-1:0] V2   = 64'h000D_000C_000B_000A;
  localparam logic [N*W-1:0] BEEF = 64'hBEEF_BEEF_BEEF_BEEF;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  int acc = 0;
  bit beef_seen;
  int a0;
  layer_stream_sequencer_if #(.NUM_INPUT(N), .INPUT_WIDTH(W)) bus ();
  layer_stream_sequencer #(.NUM_INPUT(N), .INPUT_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.elem_valid && bus.elem_ready) acc <= acc + 1;
    if (bus.elem_valid && bus.elem_data == 16'hBEEF) beef_seen <= 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic beat(input string tag, input logic [15:0] d, input int i, input logic l);
    check({tag, "_valid"}, 32'(bus.elem_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.elem_data), 32'(d));
    check({tag, "_index"}, 32'(bus.index), 32'(i));
    check({tag, "_last"}, 32'(bus.last), 32'(l));
  endtask
  task automatic capture(input logic [N*W-1:0] v);
    bus.vec_data = v;
    bus.vec_valid = 1'b1;
    step();
    bus.vec_valid = 1'b0;
  endtask
  task automatic idle_check(input string tag);
    check({tag, "_ready"}, 32'(bus.vec_ready), 32'd1);
    check({tag, "_valid"}, 32'(bus.elem_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_last"}, 32'(bus.last), 32'd0);
    check({tag, "_index"}, 32'(bus.index), 32'd0);
  endtask
  initial begin
    logic [7:0] cap, ph;
    logic [N*W-1:0] pat;
    rst_n = 1'b0;
    bus.vec_data = '0;
    bus.vec_valid = 1'b0;
    bus.elem_ready = 1'b1;
    bus.clear_overrun = 1'b0;
    step();
    step();
    idle_check("reset");
    check("reset_data", 32'(bus.elem_data), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    step();
    // basic stream
    capture(V1);
    check("basic_busy", 32'(bus.busy), 32'd1);
    check("basic_ready", 32'(bus.vec_ready), 32'd0);
    for (int k = 0; k < N; k++) begin
      beat($sformatf("basic%0d", k), 16'(k + 1), k, k == N - 1);
      step();
    end
    idle_check("basic_end");
    // backpressure on element 1
    a0 = acc;
    capture(V1);
    beat("bp0", 16'h0001, 0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("bp_hold%0d", i), 16'h0002, 1, 1'b0);
      bus.elem_ready = 1'b0;
      step();
    end
    bus.elem_ready = 1'b1;
    beat("bp_release", 16'h0002, 1, 1'b0);
    step();
    beat("bp2", 16'h0003, 2, 1'b0);
    step();
    beat("bp3", 16'h0004, 3, 1'b1);
    step();
    idle_check("bp_end");
    check("bp_beats", 32'(acc - a0), 32'd4);
    // overrun while streaming, then clear
    capture(V1);
    bus.vec_data = BEEF;
    bus.vec_valid = 1'b1;
    step();
    bus.vec_valid = 1'b0;
    check("ovr_set", 32'(bus.overrun), 32'd1);
    beat("ovr1", 16'h0002, 1, 1'b0);
    step();
    beat("ovr2", 16'h0003, 2, 1'b0);
    step();
    beat("ovr3", 16'h0004, 3, 1'b1);
    step();
    idle_check("ovr_end");
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    bus.clear_overrun = 1'b1;
    step();
    bus.clear_overrun = 1'b0;
    check("ovr_clear", 32'(bus.overrun), 32'd0);
    // set and clear in the same cycle
    capture(V1);
    bus.vec_data = BEEF;
    bus.vec_valid = 1'b1;
    step();
    check("ovr2_set", 32'(bus.overrun), 32'd1);
    bus.clear_overrun = 1'b1;
    step();
    check("ovr2_set_wins", 32'(bus.overrun), 32'd1);
    beat("ovr2_beat2", 16'h0003, 2, 1'b0);
    bus.vec_valid = 1'b0;
    step();
    bus.clear_overrun = 1'b0;
    check("ovr2_clear", 32'(bus.overrun), 32'd0);
    beat("ovr2_beat3", 16'h0004, 3, 1'b1);
    step();
    idle_check("ovr2_end");
    check("beef_never", 32'(beef_seen), 32'd0);
    // reset mid-stream after index 1 accepted
    capture(V1);
    bus.vec_valid = 1'b1;
    step();
    bus.vec_valid = 1'b0;
    check("rst_pre_ovr", 32'(bus.overrun), 32'd1);
    step();
    beat("rst_pre", 16'h0003, 2, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_check("rst_mid");
    check("rst_mid_overrun", 32'(bus.overrun), 32'd0);
    a0 = acc;
    step();
    step();
    step();
    check("rst_no_beats", 32'(acc - a0), 32'd0);
    check("rst_still_idle", 32'(bus.elem_valid), 32'd0);
    capture(V2);
    for (int k = 0; k < N; k++) begin
      beat($sformatf("rst_new%0d", k), 16'(10 + k), k, k == N - 1);
      step();
    end
    idle_check("rst_new_end");
    // back-to-back: i_valid held high with a new vector every cycle
    for (int c = 0; c < 15; c++) begin
      for (int k = 0; k < N; k++) pat[k*W +: W] = {8'(c), 8'(k)};
      bus.vec_data = pat;
      bus.vec_valid = 1'b1;
      step();
      ph = 8'(c % 5);
      cap = 8'(c) - ph;
      if (ph < 8'd4) begin
        beat($sformatf("b2b%0d", c), {cap, ph}, int'(ph), ph == 8'd3);
        check($sformatf("b2b%0d_ready", c), 32'(bus.vec_ready), 32'd0);
      end else begin
        check($sformatf("b2b%0d_ready", c), 32'(bus.vec_ready), 32'd1);
        check($sformatf("b2b%0d_valid", c), 32'(bus.elem_valid), 32'd0);
      end
    end
    bus.vec_valid = 1'b0;
    check("b2b_overrun", 32'(bus.overrun), 32'd1);
    // capture isolation with i_data changing every cycle
    capture(V2);
    for (int k = 0; k < N; k++) begin
      bus.vec_data = {$urandom, $urandom};
      beat($sformatf("iso%0d", k), 16'(10 + k), k, k == N - 1);
      step();
    end
    idle_check("iso_end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
